// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: state encoding, burst length and test pattern shared by the memory BIST.
package mem_bist_pkg;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_DONE} state_t;

    localparam int BURST = 4;

    function automatic logic [31:0] pat(input logic [29:0] a, input logic inv, input logic [31:0] seed);
        return {a, 2'b00} ^ seed ^ {32{inv}};
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: 32-bit mem_* word bus between an initiator (master) and the SRAM controller (slave).
interface mem_bist_if;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;

    modport master (
        input  mem_waitrequest, mem_readdata, mem_readdataid,
        output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );

    modport slave (
        output mem_waitrequest, mem_readdata, mem_readdataid,
        input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );
endinterface

// File: rtl/mem_bist_check.sv
// mem_bist_check: compares returned read words, keeps a saturating error count and latches the first failure.
module mem_bist_check (
    input  logic        clock,
    input  logic        rst,
    input  logic        clear,
    input  logic        valid,
    input  logic [29:0] address,
    input  logic [31:0] expected,
    input  logic [31:0] actual,
    output logic        mismatch,
    output logic [15:0] error_count,
    output logic [29:0] fail_address,
    output logic [31:0] fail_actual
);
    logic [15:0] count_q, count_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] act_q, act_d;

    assign mismatch = valid && (actual != expected);

    always_comb begin
        count_d = count_q;
        addr_d  = addr_q;
        act_d   = act_q;
        if (clear) begin
            count_d = '0;
            addr_d  = '0;
            act_d   = '0;
        end else if (mismatch) begin
            count_d = &count_q ? count_q : count_q + 16'd1;
            // a zero count means nothing has been latched since the last clear
            if (count_q == '0) begin
                addr_d = address;
                act_d  = actual;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            addr_q  <= '0;
            act_q   <= '0;
        end else begin
            count_q <= count_d;
            addr_q  <= addr_d;
            act_q   <= act_d;
        end
    end

    assign error_count  = count_q;
    assign fail_address = addr_q;
    assign fail_actual  = act_q;
endmodule

// File: rtl/mem_bist.sv
// mem_bist: writes an address-derived pattern over a word range, reads it back in 4-word bursts and reports errors.
// Define MEM_BIST_INVERT_PASS_EN to add a second write/read pass with the inverted pattern.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter logic [29:0] BASE    = 30'h1000_0000,
    parameter int          WORDS   = 1024,
    parameter logic [31:0] SEED    = 32'h5a5a_a5a5,
    parameter logic [1:0]  ID      = 2'd2,
    parameter int          TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    mem_bist_if.master  mem,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [29:0] fail_address,
    output logic [31:0] fail_actual,
    output logic [15:0] error_count
);
`ifdef MEM_BIST_INVERT_PASS_EN
    localparam bit TWO_PASS = 1'b1;
`else
    localparam bit TWO_PASS = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [24:0] off_q, off_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] timer_q, timer_d;
    logic        inv_q, inv_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
    logic        accept, clear, rd_valid, mismatch;
    logic [29:0] addr;

    assign addr     = BASE + 30'(off_q);
    assign accept   = !mem.mem_waitrequest;
    assign clear    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign rd_valid = (state_q == S_RD_WAIT) && (mem.mem_readdataid == ID);

    assign mem.mem_write         = state_q == S_WRITE;
    assign mem.mem_read          = state_q == S_RD_REQ;
    assign mem.mem_id            = mem.mem_read ? ID : 2'd0;
    assign mem.mem_address       = (mem.mem_read || mem.mem_write) ? addr : '0;
    assign mem.mem_writedata     = mem.mem_write ? pat(addr, inv_q, SEED) : '0;
    assign mem.mem_writedatamask = 4'hf;

    assign busy    = state_q == S_WRITE || state_q == S_RD_REQ || state_q == S_RD_WAIT;
    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        k_d       = k_q;
        timer_d   = timer_q;
        inv_d     = inv_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        if (clear) begin
            state_d   = S_WRITE;
            off_d     = '0;
            inv_d     = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == S_WRITE && accept) begin
            off_d   = (off_q == 25'(WORDS - 1)) ? '0 : off_q + 25'd1;
            state_d = (off_q == 25'(WORDS - 1)) ? S_RD_REQ : S_WRITE;
        end else if (state_q == S_RD_REQ && accept) begin
            state_d = S_RD_WAIT;
            k_d     = '0;
            timer_d = '0;
        end else if (state_q == S_RD_WAIT) begin
            timer_d = timer_q + 16'd1;
            k_d     = rd_valid ? k_q + 2'd1 : k_q;
            // the final word of a burst wins over a timeout landing in the same cycle
            if (rd_valid && k_q == 2'(BURST - 1)) begin
                if (off_q != 25'(WORDS - BURST)) begin
                    off_d   = off_q + 25'(BURST);
                    state_d = S_RD_REQ;
                end else if (TWO_PASS && !inv_q) begin
                    off_d   = '0;
                    inv_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (error_count == '0) && !mismatch;
                end
            end else if (timer_q == 16'(TIMEOUT)) begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                pass_d    = 1'b0;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            off_q     <= '0;
            k_q       <= '0;
            timer_q   <= '0;
            inv_q     <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            inv_q     <= inv_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    mem_bist_check u_check (
        .clock        (clock),
        .rst          (rst),
        .clear        (clear),
        .valid        (rd_valid),
        .address      (addr + 30'(k_q)),
        .expected     (pat(addr + 30'(k_q), inv_q, SEED)),
        .actual       (mem.mem_readdata),
        .mismatch     (mismatch),
        .error_count  (error_count),
        .fail_address (fail_address),
        .fail_actual  (fail_actual)
    );
endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: memory-model bench for mem_bist (16 words at address 0, 20-cycle burst timeout).
module tb_mem_bist;
    localparam logic [31:0] SEED  = 32'h5a5a_a5a5;
    localparam logic [1:0]  ID    = 2'd2;
    localparam int          WORDS = 16;
    localparam int          TMO   = 20;

    logic clock = 1'b0, rst = 1'b0, start = 1'b0;
    logic busy, done, pass, timeout;
    logic [29:0] fail_address;
    logic [31:0] fail_actual;
    logic [15:0] error_count;

    mem_bist_if bus ();

    mem_bist #(.BASE(30'd0), .WORDS(WORDS), .SEED(SEED), .ID(ID), .TIMEOUT(TMO)) dut (
        .clock(clock), .rst(rst), .start(start), .mem(bus),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_address(fail_address), .fail_actual(fail_actual), .error_count(error_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    // memory model configuration and logs
    logic [31:0] mem_arr [16];
    bit          cor_v [16];
    logic [31:0] cor_d [16];
    int          wait_cfg = 0;
    bit          ilv = 0, drop = 0;
    int          waddr[$], raddr[$], rq[$];
    logic [31:0] wdata[$];
    int          unstable = 0, acc_cyc = 0;

    typedef struct {
        int          cor_addr;
        logic [31:0] cor_val;
        int          waits;
        bit          ilv;
        bit          exp_pass;
        logic [15:0] exp_err;
        logic [29:0] exp_fa;
        logic [31:0] exp_fact;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [31:0] exp_pat(input int a);
        logic [29:0] w;
        w = 30'(a);
        return {w, 2'b00} ^ SEED;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // slave side: stalls each request wait_cfg cycles, returns read words in order one cycle after acceptance
    initial begin
        int stall, rdelay, a;
        bit snap_v;
        logic [69:0] snap, cur;
        stall = 0; rdelay = 0; snap_v = 0; snap = '0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = '0;
        bus.mem_readdataid  = '0;
        forever begin
            @(negedge clock);
            if (!rst) begin
                stall = 0; rdelay = 0; snap_v = 0;
                rq.delete();
                bus.mem_waitrequest = 1'b0;
                bus.mem_readdataid  = '0;
                bus.mem_readdata    = '0;
            end else begin
                cur = {bus.mem_read, bus.mem_write, bus.mem_id, bus.mem_address, bus.mem_writedata, bus.mem_writedatamask};
                if ((bus.mem_read || bus.mem_write) && snap_v && cur != snap) unstable++;
                if ((bus.mem_read || bus.mem_write) && stall < wait_cfg) begin
                    bus.mem_waitrequest = 1'b1;
                    if (!snap_v) begin snap = cur; snap_v = 1; end
                    stall++;
                end else begin
                    bus.mem_waitrequest = 1'b0;
                    stall = 0; snap_v = 0;
                    if (bus.mem_write) begin
                        mem_arr[bus.mem_address[3:0]] = bus.mem_writedata;
                        waddr.push_back(int'(bus.mem_address));
                        wdata.push_back(bus.mem_writedata);
                    end
                    if (bus.mem_read) begin
                        raddr.push_back(int'(bus.mem_address));
                        acc_cyc = cyc + 1;
                        for (int k = 0; k < (drop ? 3 : 4); k++) rq.push_back(int'(bus.mem_address) + k);
                        rdelay = 1;
                    end
                end
                if (ilv && $urandom_range(0, 2) == 0) begin
                    bus.mem_readdataid = 2'd1;
                    bus.mem_readdata   = $urandom;
                end else if (rq.size() > 0 && rdelay == 0) begin
                    a = rq.pop_front();
                    bus.mem_readdataid = ID;
                    bus.mem_readdata   = cor_v[a] ? cor_d[a] : mem_arr[a];
                end else begin
                    bus.mem_readdataid = 2'd0;
                    bus.mem_readdata   = $urandom;
                end
                if (rdelay > 0) rdelay--;
            end
        end
    end

    // reference: every word should read back as the written pattern unless the model corrupts it
    task automatic model(output bit p, output logic [15:0] e, output logic [29:0] fa, output logic [31:0] fv);
        logic [31:0] v;
        e = 0; fa = 0; fv = 0;
        for (int a = 0; a < WORDS; a++) begin
            v = cor_v[a] ? cor_d[a] : exp_pat(a);
            if (v != exp_pat(a)) begin
                if (e == 0) begin fa = 30'(a); fv = v; end
                e++;
            end
        end
        p = (e == 0);
    endtask

    task automatic clear_cor();
        for (int a = 0; a < WORDS; a++) begin cor_v[a] = 0; cor_d[a] = '0; end
    endtask

    task automatic run(output bit ok);
        waddr.delete(); wdata.delete(); raddr.delete();
        unstable = 0;
        chk("idle_not_busy", busy, 0);
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared_on_start", {done, pass, timeout}, 3'b000);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin ok = 1; break; end
            @(negedge clock);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL run_budget: done=%0b after 4000 cycles, required 1", done);
        end
    endtask

    task automatic check_result(input string tag, input bit p, input logic [15:0] e,
                                input logic [29:0] fa, input logic [31:0] fv);
        bit ok;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_pass"}, pass, p);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_error_count"}, error_count, e);
        chk({tag, "_fail_address"}, fail_address, fa);
        chk({tag, "_fail_actual"}, fail_actual, fv);
        chk({tag, "_stable_while_stalled"}, unstable, 0);
        ok = (waddr.size() == WORDS);
        for (int i = 0; ok && i < WORDS; i++) ok = (waddr[i] == i) && (wdata[i] == exp_pat(i));
        chk({tag, "_write_sequence"}, ok, 1);
        ok = (raddr.size() == WORDS / 4);
        for (int i = 0; ok && i < WORDS / 4; i++) ok = (raddr[i] == 4 * i);
        chk({tag, "_burst_addresses"}, ok, 1);
    endtask

    initial begin
        bit ok, p;
        logic [15:0] e;
        logic [29:0] fa;
        logic [31:0] fv;
        int n, a;

        vecs[0] = '{-1, 32'h0,         0, 0, 1, 16'd0, 30'd0,  32'h0};
        vecs[1] = '{6,  32'hdead_beef, 0, 0, 0, 16'd1, 30'd6,  32'hdead_beef};
        vecs[2] = '{-1, 32'h0,         5, 0, 1, 16'd0, 30'd0,  32'h0};
        vecs[3] = '{-1, 32'h0,         0, 1, 1, 16'd0, 30'd0,  32'h0};
        vecs[4] = '{15, 32'h0,         2, 1, 0, 16'd1, 30'd15, 32'h0};

        clear_cor();
        #12;
        chk("reset_outputs", {bus.mem_read, bus.mem_write, busy, done, pass, timeout, bus.mem_id, bus.mem_address,
             bus.mem_writedata, error_count, fail_address, fail_actual, bus.mem_writedatamask}, {148'd0, 4'hf});
        @(negedge clock) rst = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            clear_cor();
            if (vecs[i].cor_addr >= 0) begin
                cor_v[vecs[i].cor_addr] = 1;
                cor_d[vecs[i].cor_addr] = vecs[i].cor_val;
            end
            wait_cfg = vecs[i].waits;
            ilv = vecs[i].ilv;
            run(ok);
            check_result($sformatf("vec%0d", i), vecs[i].exp_pass, vecs[i].exp_err, vecs[i].exp_fa, vecs[i].exp_fact);
        end

        // only 3 words of the first burst come back
        clear_cor(); wait_cfg = 0; ilv = 0; drop = 1;
        run(ok);
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 1);
        chk("to_pass", pass, 0);
        chk("to_latency", cyc - acc_cyc, 21);
        drop = 0;

        for (int t = 0; t < 6; t++) begin
            clear_cor();
            wait_cfg = $urandom_range(0, 3);
            ilv = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                a = $urandom_range(0, WORDS - 1);
                cor_v[a] = 1;
                cor_d[a] = $urandom;
            end
            model(p, e, fa, fv);
            run(ok);
            check_result($sformatf("rand%0d", t), p, e, fa, fv);
        end

        // reset in the middle of the write phase, then a clean restart
        clear_cor(); wait_cfg = 0; ilv = 0;
        waddr.delete(); wdata.delete(); raddr.delete();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int i = 0; i < 100 && waddr.size() < 5; i++) @(negedge clock);
        #2 rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {bus.mem_read, bus.mem_write, busy, done, pass, timeout, bus.mem_id, bus.mem_address,
             bus.mem_writedata, error_count, fail_address, fail_actual, bus.mem_writedatamask}, {148'd0, 4'hf});
        @(negedge clock);
        chk("reset_hold_outputs", {bus.mem_read, bus.mem_write, busy, done, bus.mem_address}, 34'd0);
        rst = 1'b1;
        @(negedge clock);
        run(ok);
        check_result("after_reset", 1, 16'd0, 30'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
